rr_grant_sequencer_4: RTL and testbench

- Four-requester round-robin arbiter with hold/release control.
- Sits directly upstream of the 2-to-4 decoder: its `ena`/`sel` outputs drive the decoder's enable and 2-bit select, which yields a one-hot grant vector.
- Adds fairness, grant hold until release, and a hold-time watchdog, none of which the decoder provides.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_grant_sequencer_4_pick.sv | 33 +++
 rtl/rr_grant_sequencer_4.sv | 114 +++++++++++
 tb/tb_rr_grant_sequencer_4.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant sequencer.
//   state_t   : FSM encoding (IDLE / GRANT / GAP), 2 bits
//   NUM_REQ   : number of requesters
//   req_vec_t : one bit per requester
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_grant_sequencer_4_pick.sv
// rr_pick_4: combinational round-robin winner selection.
//   ptr     in  2  priority pointer; scanning starts here
//   req     in  4  request vector
//   winner  out 2  first set bit of req at or above ptr, wrapping 3->0
//   any_req out 1  req != 0
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [1:0] ptr,
    input  req_vec_t   req,
    output logic [1:0] winner,
    output logic       any_req
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        winner  = 2'd0;
        found   = 1'b0;
        idx     = 2'd0;
        any_req = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            // 2-bit add wraps naturally from 3 back to 0
            idx = ptr + i[1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_sequencer_4.sv
// rr_grant_sequencer_4: four-requester round-robin arbiter with hold until
// release, a one-cycle gap between owners and a hold-time watchdog.
// Drives the enable/select of a downstream 2-to-4 decoder.
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   req     in  4  request vector
//   done    in  1  owner releases the grant (only looked at in GRANT)
//   ena     out 1  grant valid (decoder enable)
//   sel     out 2  current owner (decoder select)
//   timeout out 1  one-cycle pulse when the watchdog revoked the grant
//   busy    out 1  state != IDLE
module rr_grant_sequencer_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  req_vec_t   req,
    input  logic       done,
    output logic       ena,
    output logic [1:0] sel,
    output logic       timeout,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ena_q, ena_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic [1:0] winner;
    logic       any_req;
    logic       expired;
    logic       release_req;

    rr_pick_4 u_pick (
        .ptr     (ptr_q),
        .req     (req),
        .winner  (winner),
        .any_req (any_req)
    );

    // An explicit release (done or owner withdrawal) takes precedence over
    // the watchdog, so a coincident expiry is not flagged as a timeout.
    assign expired     = (cnt_q == CNT_LAST);
    assign release_req = done || !req[sel_q];

    // State register (outputs are registered alongside)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            ena_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ena_q     <= ena_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d   = winner;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (release_req || expired) begin
                    ptr_d   = sel_q + 2'd1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        ena_d     = (state_d == GRANT);
        busy_d    = (state_d != IDLE);
        timeout_d = (state_q == GRANT) && expired && !release_req;
    end

    assign ena     = ena_q;
    assign sel     = sel_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rr_grant_sequencer_4.sv
// Directed bench for rr_grant_sequencer_4 built with MAX_HOLD=4.
// Inputs change 1 time unit after the rising edge; outputs are checked
// right after that, well away from the next edge.
module tb_rr_grant_sequencer_4;
    import arb_pkg::*;

    logic       clk;
    logic       rst_n;
    req_vec_t   req;
    logic       done;
    logic       ena;
    logic [1:0] sel;
    logic       timeout;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    rr_grant_sequencer_4 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .ena     (ena),
        .sel     (sel),
        .timeout (timeout),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full output set in one call
    task automatic chk_out(input string tag, input logic e, input logic [1:0] s,
                           input logic t, input logic b);
        chk({tag, ".ena"}, 32'(ena), 32'(e));
        if (e) chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        #2;
        do_reset();
        chk_out("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        chk("reset.sel", 32'(sel), 32'd0);

        // ---- reset mid-grant ----
        req = 4'b0100;
        tick();
        chk_out("midrst.grant", 1'b1, 2'd2, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst.ena_async", 32'(ena), 32'd0);
        chk("midrst.sel", 32'(sel), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        // pointer back to 0: all requesting -> requester 0 wins
        req = 4'b1111;
        tick();
        chk_out("midrst.ptr0", 1'b1, 2'd0, 1'b0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        chk_out("midrst.gap", 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("midrst.idle", 1'b0, 2'd0, 1'b0, 1'b0);

        // ---- single requester, done after 3 grant cycles (ptr=1) ----
        req = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk_out($sformatf("single.c%0d", c), 1'b1, 2'd2, 1'b0, 1'b1);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_out("single.gap", 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("single.idle", 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("single.regrant", 1'b1, 2'd2, 1'b0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        tick();

        // ---- fairness from pointer 0 ----
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk_out($sformatf("fair.g%0d", g), 1'b1, 2'(g % 4), 1'b0, 1'b1);
            done = 1'b1;
            tick();
            done = 1'b0;
            chk_out($sformatf("fair.gap%0d", g), 1'b0, 2'd0, 1'b0, 1'b1);
            tick();
            chk_out($sformatf("fair.idle%0d", g), 1'b0, 2'd0, 1'b0, 1'b0);
        end
        req = '0;
        tick();
        chk_out("fair.stay_idle", 1'b0, 2'd0, 1'b0, 1'b0);

        // ---- wrap and skip: pointer is 1, grant 2 moves it to 3 ----
        req = 4'b0100;
        tick();
        chk_out("wrap.g2", 1'b1, 2'd2, 1'b0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0011;
        tick();
        tick();
        chk_out("wrap.g0", 1'b1, 2'd0, 1'b0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        chk_out("wrap.g1", 1'b1, 2'd1, 1'b0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        tick();

        // ---- watchdog: pointer 2, only requester 1 ----
        req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_out($sformatf("wdog.c%0d", c), 1'b1, 2'd1, 1'b0, 1'b1);
        end
        tick();
        chk_out("wdog.timeout", 1'b0, 2'd0, 1'b1, 1'b1);
        tick();
        chk_out("wdog.idle", 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_out("wdog.regrant", 1'b1, 2'd1, 1'b0, 1'b1);

        // ---- done in the 4th grant cycle: normal release ----
        tick();
        tick();
        tick();
        chk_out("simul.c4", 1'b1, 2'd1, 1'b0, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_out("simul.gap", 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        tick();
        chk_out("withdraw.grant", 1'b1, 2'd1, 1'b0, 1'b1);
        tick();
        req = '0;
        tick();
        chk_out("withdraw.gap", 1'b0, 2'd0, 1'b0, 1'b1);
        tick();
        chk_out("withdraw.idle", 1'b0, 2'd0, 1'b0, 1'b0);

        // ---- done outside GRANT is ignored ----
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        chk_out("done_idle", 1'b0, 2'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
